// File: rtl/hack_alu_pkg.sv
// Shared definitions for the Hack ALU: word size, control-bit layout and the
// {zx,nx,zy,ny,f,no} encodings of the standard Hack functions.
package hack_alu_pkg;

    localparam int HACK_WORD = 16;
    localparam int CTRL_W    = 6;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

    localparam logic [CTRL_W-1:0] C_ZERO  = 6'b101010;
    localparam logic [CTRL_W-1:0] C_ONE   = 6'b111111;
    localparam logic [CTRL_W-1:0] C_NEG1  = 6'b111010;
    localparam logic [CTRL_W-1:0] C_X     = 6'b001100;
    localparam logic [CTRL_W-1:0] C_Y     = 6'b110000;
    localparam logic [CTRL_W-1:0] C_NOTX  = 6'b001101;
    localparam logic [CTRL_W-1:0] C_NOTY  = 6'b110001;
    localparam logic [CTRL_W-1:0] C_NEGX  = 6'b001111;
    localparam logic [CTRL_W-1:0] C_NEGY  = 6'b110011;
    localparam logic [CTRL_W-1:0] C_XP1   = 6'b011111;
    localparam logic [CTRL_W-1:0] C_YP1   = 6'b110111;
    localparam logic [CTRL_W-1:0] C_XM1   = 6'b001110;
    localparam logic [CTRL_W-1:0] C_YM1   = 6'b110010;
    localparam logic [CTRL_W-1:0] C_XPY   = 6'b000010;
    localparam logic [CTRL_W-1:0] C_XMY   = 6'b010011;
    localparam logic [CTRL_W-1:0] C_YMX   = 6'b000111;
    localparam logic [CTRL_W-1:0] C_XANDY = 6'b000000;
    localparam logic [CTRL_W-1:0] C_XORY  = 6'b010101;

endpackage

// File: rtl/hack_alu_core.sv
// Combinational Hack ALU: operand zero/invert stages, add-or-and, output
// invert, plus zero and negative status of the result.
module hack_alu_core
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = HACK_WORD
) (
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic [CTRL_W-1:0] ctrl,
    output logic [WIDTH-1:0]  res,
    output logic              zr_c,
    output logic              ng_c
);

    alu_ctrl_t c;
    logic [WIDTH-1:0] x1, x2, y1, y2, r;

    assign c = alu_ctrl_t'(ctrl);

    always_comb begin
        x1 = c.zx ? '0 : x;
        x2 = c.nx ? ~x1 : x1;
        y1 = c.zy ? '0 : y;
        y2 = c.ny ? ~y1 : y1;
        // Modular add: the carry out of the top bit is dropped on purpose.
        r    = c.f ? (x2 + y2) : (x2 & y2);
        res  = c.no ? ~r : r;
        zr_c = (res == '0);
        ng_c = res[WIDTH-1];
    end

endmodule

// File: rtl/hack_alu.sv
// Hack ALU with one registered output stage and a valid flag; zr/ng are
// captured together with out so they always describe the held result.
module hack_alu
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = HACK_WORD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             zx,
    input  logic             nx,
    input  logic             zy,
    input  logic             ny,
    input  logic             f,
    input  logic             no,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    logic [WIDTH-1:0] res;
    logic             zr_c, ng_c;

    logic [WIDTH-1:0] out_d, out_q;
    logic             zr_d, zr_q;
    logic             ng_d, ng_q;
    logic             out_valid_d, out_valid_q;

    hack_alu_core #(.WIDTH(WIDTH)) u_core (
        .x    (x),
        .y    (y),
        .ctrl ({zx, nx, zy, ny, f, no}),
        .res  (res),
        .zr_c (zr_c),
        .ng_c (ng_c)
    );

    always_comb begin
        out_d       = out_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        out_valid_d = in_valid;
        if (in_valid) begin
            out_d = res;
            zr_d  = zr_c;
            ng_d  = ng_c;
        end
    end

    // Output stage: reset state must read as a zero result (zr=1, ng=0).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            zr_q        <= 1'b1;
            ng_q        <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_hack_alu.sv
// Self-checking bench for hack_alu: directed vector table, pipeline/reset
// sequences, and random stimulus against a behavioural reference.
module tb_hack_alu;
    import hack_alu_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] x, y;
    logic         zx, nx, zy, ny, f, no;
    logic         out_valid;
    logic [W-1:0] out;
    logic         zr, ng;

    int n_tests = 0;
    int n_fail  = 0;

    hack_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .x(x), .y(y),
        .zx(zx), .nx(nx), .zy(zy), .ny(ny), .f(f), .no(no),
        .out_valid(out_valid), .out(out), .zr(zr), .ng(ng)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string        name;
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [5:0]   ctrl;
        logic [W-1:0] e_out;
        logic         e_zr;
        logic         e_ng;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all(input string name, input logic [W-1:0] e_out, input logic e_vld);
        check({name, ".out"}, out, e_out);
        check({name, ".zr"}, W'(zr), W'(e_out == '0));
        check({name, ".ng"}, W'(ng), W'(e_out[W-1]));
        check({name, ".vld"}, W'(out_valid), W'(e_vld));
    endtask

    // Drive one cycle of inputs, clock it, and settle just after the edge.
    task automatic step(input logic r, input logic iv, input logic [W-1:0] xv,
                        input logic [W-1:0] yv, input logic [5:0] c);
        rst = r;
        in_valid = iv;
        x = xv;
        y = yv;
        {zx, nx, zy, ny, f, no} = c;
        @(posedge clk);
        #1;
    endtask

    // Named Hack functions expressed as ordinary arithmetic on the operands.
    function automatic logic [W-1:0] hack_fn(input logic [5:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        case (c)
            C_ZERO:  return 16'd0;
            C_ONE:   return 16'd1;
            C_NEG1:  return -16'sd1;
            C_X:     return a;
            C_Y:     return b;
            C_NOTX:  return ~a;
            C_NOTY:  return ~b;
            C_NEGX:  return -a;
            C_NEGY:  return -b;
            C_XP1:   return a + 16'd1;
            C_YP1:   return b + 16'd1;
            C_XM1:   return a - 16'd1;
            C_YM1:   return b - 16'd1;
            C_XPY:   return a + b;
            C_XMY:   return a - b;
            C_YMX:   return b - a;
            C_XANDY: return a & b;
            C_XORY:  return a | b;
            default: return 16'hxxxx;
        endcase
    endfunction

    // General rule for any control word, using integer arithmetic and masking.
    function automatic logic [W-1:0] rule_fn(input logic [5:0] c, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int unsigned xa, yb, r, mask;
        mask = 32'h0000_FFFF;
        xa = c[5] ? 0 : int'(a);
        if (c[4]) xa = mask - xa;
        yb = c[3] ? 0 : int'(b);
        if (c[2]) yb = mask - yb;
        r = c[1] ? ((xa + yb) % 65536) : (xa & yb);
        if (c[0]) r = mask - r;
        return r[W-1:0];
    endfunction

    logic [5:0] named[18] = '{C_ZERO, C_ONE, C_NEG1, C_X, C_Y, C_NOTX, C_NOTY, C_NEGX, C_NEGY,
                              C_XP1, C_YP1, C_XM1, C_YM1, C_XPY, C_XMY, C_YMX, C_XANDY, C_XORY};

    initial begin
        logic [W-1:0] exp_out;
        logic         exp_vld;

        vecs.push_back('{"and",     16'h00FF, 16'h0F0F, 6'b000000, 16'h000F, 1'b0, 1'b0});
        vecs.push_back('{"nand",    16'h00FF, 16'h0F0F, 6'b000001, 16'hFFF0, 1'b0, 1'b1});
        vecs.push_back('{"add",     16'h00FF, 16'h0001, 6'b000010, 16'h0100, 1'b0, 1'b0});
        vecs.push_back('{"add_ovf", 16'h7FFF, 16'h0001, 6'b000010, 16'h8000, 1'b0, 1'b1});
        vecs.push_back('{"add_wrap",16'hFFFF, 16'h0001, 6'b000010, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{"zx",      16'h00FF, 16'h0F0F, 6'b100000, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{"nx",      16'h00FF, 16'h0F0F, 6'b010000, 16'h0F00, 1'b0, 1'b0});
        vecs.push_back('{"zy",      16'h00FF, 16'h0F0F, 6'b001000, 16'h0000, 1'b1, 1'b0});
        vecs.push_back('{"ny",      16'h00FF, 16'h0F0F, 6'b000100, 16'h00F0, 1'b0, 1'b0});
        vecs.push_back('{"xmy",     16'h0005, 16'h0003, C_XMY,     16'h0002, 1'b0, 1'b0});
        vecs.push_back('{"ymx",     16'h0005, 16'h0003, C_YMX,     16'hFFFE, 1'b0, 1'b1});
        vecs.push_back('{"negx",    16'h0005, 16'h0003, C_NEGX,    16'hFFFB, 1'b0, 1'b1});
        vecs.push_back('{"one",     16'h0005, 16'h0003, C_ONE,     16'h0001, 1'b0, 1'b0});
        vecs.push_back('{"neg1",    16'h0005, 16'h0003, C_NEG1,    16'hFFFF, 1'b0, 1'b1});
        vecs.push_back('{"xory",    16'h0005, 16'h0003, C_XORY,    16'h0007, 1'b0, 1'b0});

        // Reset state
        step(1'b1, 1'b0, '0, '0, '0);
        step(1'b1, 1'b0, '0, '0, '0);
        check_all("reset", 16'h0000, 1'b0);

        // Directed table
        foreach (vecs[i]) begin
            step(1'b0, 1'b1, vecs[i].x, vecs[i].y, vecs[i].ctrl);
            check({vecs[i].name, ".out"}, out, vecs[i].e_out);
            check({vecs[i].name, ".zr"}, W'(zr), W'(vecs[i].e_zr));
            check({vecs[i].name, ".ng"}, W'(ng), W'(vecs[i].e_ng));
            check({vecs[i].name, ".vld"}, W'(out_valid), 16'd1);
        end

        // Back-to-back results, then one idle cycle holds out
        step(1'b0, 1'b1, 16'h0010, 16'h0020, C_XPY);
        check_all("b2b_0", 16'h0030, 1'b1);
        step(1'b0, 1'b1, 16'h0010, 16'h0020, C_YMX);
        check_all("b2b_1", 16'h0010, 1'b1);
        step(1'b0, 1'b0, 16'hAAAA, 16'h5555, C_XPY);
        check_all("idle_hold", 16'h0010, 1'b0);

        // Reset wins over a valid input, next valid shows one cycle later
        step(1'b1, 1'b1, 16'h1234, 16'h0000, C_X);
        check_all("rst_prio", 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h1234, 16'h0000, C_X);
        check_all("post_rst", 16'h1234, 1'b1);

        // Random named functions against arithmetic semantics
        for (int i = 0; i < 150; i++) begin
            logic [W-1:0] a, b;
            logic [5:0]   c;
            a = W'($urandom);
            b = W'($urandom);
            c = named[$urandom_range(0, 17)];
            step(1'b0, 1'b1, a, b, c);
            check_all($sformatf("named_%0d_c%b", i, c), hack_fn(c, a, b), 1'b1);
        end

        // Random control words and valid gaps against the general rule
        exp_out = out;
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] a, b;
            logic [5:0]   c;
            logic         iv;
            a  = W'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? (~a + 16'd1) : W'($urandom);
            c  = 6'($urandom);
            iv = ($urandom_range(0, 3) != 0);
            if (iv) exp_out = rule_fn(c, a, b);
            exp_vld = iv;
            step(1'b0, iv, a, b, c);
            check_all($sformatf("rand_%0d_c%b", i, c), exp_out, exp_vld);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
